// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   state_t     : receiver FSM states (PARITY is only entered when the
//                 UART_RX_PARITY_EN macro is defined)
//   PARITY_EVEN : parity_odd value selecting even parity
//   PARITY_ODD  : parity_odd value selecting odd parity
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_frame_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_if
// Output stream of the UART receiver.
//   m_data     : received word, LSB is the first bit on the line
//   m_valid    : m_data and the error flags are valid
//   m_ready    : consumer accepts the word
//   frame_err  : qualified by m_valid, a stop bit was sampled low
//   parity_err : qualified by m_valid, parity mismatch
//   overrun    : one-cycle pulse when a completed frame is dropped
// Handshake: a word moves on every clk edge where m_valid && m_ready. While
// m_valid=1 and m_ready=0 the producer holds m_data and the flags stable;
// m_valid never drops without a transfer.
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_frame_if #(
   parameter int DATA_BITS = 8
);

   logic [DATA_BITS-1:0] m_data;
   logic                 m_valid;
   logic                 m_ready;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   modport master (
      output m_data, m_valid, frame_err, parity_err, overrun,
      input  m_ready
   );

   modport slave (
      input  m_data, m_valid, frame_err, parity_err, overrun,
      output m_ready
   );

endinterface

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for a single asynchronous input.
//   clk       : destination clock
//   rst       : asynchronous active-low reset, both flops load RESET_VAL
//   d_i       : asynchronous input
//   q_o       : synchronised output
// -----------------------------------------------------------------------------
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
// Oversampling UART receiver with false-start rejection, framing-error and
// overrun detection and a valid/ready output stream.
// Optional parity check: define UART_RX_PARITY_EN to add a parity bit after
// the data bits; without it parity_odd is ignored and parity_err is 0.
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   tick        : one-cycle strobe at OVS x baud; bit timing advances on it
//   rx_serial   : asynchronous serial line, idle high
//   parity_odd  : 1 = odd parity, 0 = even parity
//   m_if        : output stream (master modport of uart_rx_frame_if)
//   busy        : receiver is not in IDLE
//   state_dbg_o : current FSM state
// -----------------------------------------------------------------------------
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int OVS       = 16,
   parameter int STOP_BITS = 1
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   tick,
   input  logic   rx_serial,
   input  logic   parity_odd,
   uart_rx_frame_if.master m_if,
   output logic   busy,
   output state_t state_dbg_o
);

   localparam int CNT_W = $clog2(OVS);
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVS / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = (STOP_BITS == 2);

   logic rx_s;

   uart_sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (rx_serial),
      .q_o (rx_s)
   );

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     bit_idx_q;
   logic                 stop_idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 ferr_q;
   logic                 perr_q;
   // Start detection is disarmed after a framing error until the line has
   // been seen high, so a break is reported once rather than as 0x00 frames.
   logic                 armed_q;

   logic [DATA_BITS-1:0] m_data_q;
   logic                 m_valid_q;
   logic                 frame_err_q;
   logic                 parity_err_q;
   logic                 overrun_q;

   // Framing error of the current frame including the stop sample taken now.
   logic ferr_d;
   // A held word can be replaced when the consumer takes it on this edge.
   logic can_load_d;

   assign ferr_d     = ferr_q | ~rx_s;
   assign can_load_d = ~m_valid_q | m_if.m_ready;

`ifndef UART_RX_PARITY_EN
   logic unused_parity_odd;
   assign unused_parity_odd = parity_odd;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         stop_idx_q   <= 1'b0;
         shift_q      <= '0;
         ferr_q       <= 1'b0;
         perr_q       <= 1'b0;
         armed_q      <= 1'b1;
         m_data_q     <= '0;
         m_valid_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (m_valid_q && m_if.m_ready) begin
            m_valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (tick) begin
                  if (rx_s) begin
                     armed_q <= 1'b1;
                  end else if (armed_q) begin
                     state_q <= START;
                     cnt_q   <= '0;
                  end
               end
            end

            START: begin
               if (tick) begin
                  if (cnt_q == CNT_MID) begin
                     cnt_q <= '0;
                     if (rx_s) begin
                        state_q <= IDLE;        // line went high again: glitch
                     end else begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
            end

            DATA: begin
               if (tick) begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_q              <= '0;
                     shift_q[bit_idx_q] <= rx_s;
                     if (bit_idx_q == IDX_LAST) begin
                        ferr_q     <= 1'b0;
                        stop_idx_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        state_q    <= PARITY;
`else
                        perr_q     <= 1'b0;
                        state_q    <= STOP;
`endif
                     end else begin
                        bit_idx_q <= bit_idx_q + IDX_ONE;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_q   <= '0;
                     // Expected parity bit is the data XOR, inverted for odd.
                     perr_q  <= rx_s ^ (^shift_q) ^ (parity_odd == PARITY_ODD);
                     state_q <= STOP;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
            end
`endif

            STOP: begin
               if (tick) begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_q  <= '0;
                     ferr_q <= ferr_d;
                     if (stop_idx_q == STOP_LAST) begin
                        state_q <= IDLE;
                        armed_q <= ~ferr_d;
                        if (can_load_d) begin
                           m_data_q     <= shift_q;
                           frame_err_q  <= ferr_d;
                           parity_err_q <= perr_q;
                           m_valid_q    <= 1'b1;
                        end else begin
                           overrun_q <= 1'b1;
                        end
                     end else begin
                        stop_idx_q <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
            end

            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign m_if.m_data    = m_data_q;
   assign m_if.m_valid   = m_valid_q;
   assign m_if.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
   assign m_if.parity_err = parity_err_q;
`else
   assign m_if.parity_err = 1'b0;
`endif
   assign m_if.overrun   = overrun_q;

   assign busy        = (state_q != IDLE);
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame
// Self-checking bench for uart_rx_frame (OVS=16, 8 data bits, 1 stop bit).
// Serial frames are driven bit by bit; a one-entry output-buffer model and an
// expected queue of {frame_err, parity_err, data} give the reference results.
// Builds with or without UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame;

   localparam int DATA_BITS = 8;
   localparam int OVS       = 16;
   localparam int STOP_BITS = 1;
   localparam int TICK_DIV  = 4;
   localparam int BIT_CLKS  = OVS * TICK_DIV;
   localparam int W         = DATA_BITS + 2;
`ifdef UART_RX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   // Ticks from start detection to the final stop sample.
   localparam int DONE_TICKS = OVS / 2 + (DATA_BITS + PBITS + STOP_BITS) * OVS;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic [1:0] div = 2'd0;
   logic       rx_serial = 1'b1;
   logic       parity_odd = 1'b0;
   logic       busy;
   uart_pkg::state_t state_dbg;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      div  <= div + 2'd1;
      tick <= (div == 2'd3);
   end

   uart_rx_frame_if #(.DATA_BITS(DATA_BITS)) m_if ();

   uart_rx_frame #(
      .DATA_BITS (DATA_BITS),
      .OVS       (OVS),
      .STOP_BITS (STOP_BITS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .rx_serial   (rx_serial),
      .parity_odd  (parity_odd),
      .m_if        (m_if),
      .busy        (busy),
      .state_dbg_o (state_dbg)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   int ovr_cnt  = 0;
   int n_checks = 0;
   int n_fail   = 0;

   always @(negedge clk) begin
      #1;
      if (rst) begin
         if (m_if.m_valid && m_if.m_ready)
            got_q.push_back({m_if.frame_err, m_if.parity_err, m_if.m_data});
         if (m_if.overrun) ovr_cnt++;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic drive_bit(input logic b);
      rx_serial = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop_val,
                             input logic par_flip, input logic push);
      logic pe;
      pe = (PBITS != 0) && par_flip;
      if (push) exp_q.push_back({~stop_val, pe, d});
      drive_bit(1'b0);
      for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^d) ^ parity_odd ^ par_flip);
`endif
      for (int s = 0; s < STOP_BITS; s++) drive_bit(stop_val);
      rx_serial = 1'b1;
   endtask

   // Returns at the negedge just before the edge that takes the final stop sample.
   task automatic wait_done(output bit ok);
      int n;
      int guard;
      ok = 1'b0;
      n = 0;
      guard = 0;
      while (!busy && guard < 4 * BIT_CLKS) begin
         @(negedge clk);
         guard++;
      end
      if (!busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_busy: busy=%b required 1 within %0d clks", busy, 4 * BIT_CLKS);
         return;
      end
      guard = 0;
      while (guard < (DATA_BITS + 6) * BIT_CLKS) begin
         if (tick) begin
            n++;
            if (n == DONE_TICKS) begin
               ok = 1'b1;
               return;
            end
         end
         @(negedge clk);
         guard++;
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: saw %0d ticks required %0d", n, DONE_TICKS);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      m_if.m_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      n_checks++; if (m_if.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_if.m_valid); end
      n_checks++; if (m_if.m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %h expected 00", m_if.m_data); end
      n_checks++; if (m_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", m_if.frame_err); end
      n_checks++; if (m_if.parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", m_if.parity_err); end
      n_checks++; if (m_if.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", m_if.overrun); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      @(negedge clk);
      rst = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic test_basic();
      bit ok;
      logic [W-1:0] g, e;
      m_if.m_ready = 1'b1;
      fork
         send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
         begin
            wait_done(ok);
            if (ok) begin
               n_checks++; if (m_if.m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b expected 0", m_if.m_valid); end
               @(negedge clk); #1;
               n_checks++; if (m_if.m_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_latency: got %b expected 1", m_if.m_valid); end
               n_checks++; if (m_if.m_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h expected a5", m_if.m_data); end
               n_checks++; if (m_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_frame_err: got %b expected 0", m_if.frame_err); end
               n_checks++; if (m_if.parity_err !== 1'b0) begin n_fail++; $display("FAIL basic_parity_err: got %b expected 0", m_if.parity_err); end
               @(negedge clk); #1;
               n_checks++; if (m_if.m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b expected 0", m_if.m_valid); end
            end
         end
      join
      repeat (BIT_CLKS) @(negedge clk);
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d frames expected %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) begin n_fail++; $display("FAIL basic_frame: got %h expected %h", g, e); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_glitch();
      rx_serial = 1'b0;
      repeat (12) @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b expected 1", busy); end
      repeat (4) @(negedge clk);
      rx_serial = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low: got %b expected 0", busy); end
      n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL glitch_no_frame: got %0d frames expected 0", got_q.size()); end
      got_q.delete();
   endtask

   task automatic test_random();
      logic [W-1:0] g, e;
      logic [DATA_BITS-1:0] d;
      m_if.m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         d = DATA_BITS'($urandom_range(0, (1 << DATA_BITS) - 1));
         parity_odd = 1'($urandom_range(0, 1));
         send_frame(d, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
         repeat ($urandom_range(0, 3) * OVS) @(negedge clk);
      end
      repeat (BIT_CLKS) @(negedge clk);
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d frames expected %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) begin n_fail++; $display("FAIL random_frame: got %h expected %h", g, e); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] g, e;
      m_if.m_ready = 1'b1;
      send_frame(8'h00, 1'b1, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
      send_frame(8'h81, 1'b1, 1'b1, 1'b1);
      repeat (BIT_CLKS) @(negedge clk);
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d frames expected %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) begin n_fail++; $display("FAIL b2b_frame: got %h expected %h", g, e); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_frame_err();
      logic [W-1:0] g, e;
      m_if.m_ready = 1'b1;
      parity_odd = 1'b0;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      rx_serial = 1'b0;
      repeat (3 * BIT_CLKS) @(negedge clk);
      n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL ferr_break_count: got %0d frames expected 1", got_q.size()); end
      rx_serial = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      send_frame(8'h96, 1'b1, 1'b0, 1'b1);
      repeat (BIT_CLKS) @(negedge clk);
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ferr_count: got %0d frames expected %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) begin n_fail++; $display("FAIL ferr_frame: got %h expected %h", g, e); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_overrun();
      bit ok;
      int ovr0;
      logic [W-1:0] g, e;
      @(negedge clk);
      m_if.m_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0, 1'b1);
      #1;
      n_checks++; if (m_if.m_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_held_valid: got %b expected 1", m_if.m_valid); end
      n_checks++; if (m_if.m_data !== 8'h11) begin n_fail++; $display("FAIL ovr_held_data: got %h expected 11", m_if.m_data); end
      ovr0 = ovr_cnt;
      @(negedge clk);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      #1;
      n_checks++; if (m_if.m_data !== 8'h11) begin n_fail++; $display("FAIL ovr_keep_data: got %h expected 11", m_if.m_data); end
      n_checks++; if (ovr_cnt - ovr0 != 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d pulse cycles expected 1", ovr_cnt - ovr0); end
      @(negedge clk); m_if.m_ready = 1'b1;
      @(negedge clk); m_if.m_ready = 1'b0;
      send_frame(8'h33, 1'b1, 1'b0, 1'b1);
      ovr0 = ovr_cnt;
      fork
         send_frame(8'h44, 1'b1, 1'b0, 1'b1);
         begin
            wait_done(ok);
            if (ok) begin
               m_if.m_ready = 1'b1;
               @(negedge clk);
               m_if.m_ready = 1'b0;
               #1;
               n_checks++; if (m_if.m_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_same_edge_valid: got %b expected 1", m_if.m_valid); end
               n_checks++; if (m_if.m_data !== 8'h44) begin n_fail++; $display("FAIL ovr_same_edge_data: got %h expected 44", m_if.m_data); end
            end
         end
      join
      n_checks++; if (ovr_cnt != ovr0) begin n_fail++; $display("FAIL ovr_same_edge_pulse: got %0d expected 0", ovr_cnt - ovr0); end
      m_if.m_ready = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovr_count: got %0d frames expected %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) begin n_fail++; $display("FAIL ovr_frame: got %h expected %h", g, e); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_parity();
      logic [W-1:0] g, e;
      m_if.m_ready = 1'b1;
      parity_odd = 1'b0;
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      send_frame(8'h07, 1'b1, 1'b0, 1'b1);
      parity_odd = 1'b1;
      send_frame(8'h07, 1'b1, 1'b0, 1'b1);
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      repeat (BIT_CLKS) @(negedge clk);
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL parity_count: got %0d frames expected %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) begin n_fail++; $display("FAIL parity_frame: got %h expected %h", g, e); end
      end
      got_q.delete(); exp_q.delete();
      parity_odd = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] g, e;
      m_if.m_ready = 1'b1;
      @(negedge clk);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      rx_serial = 1'b0;
      repeat (BIT_CLKS / 2) @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
      rst = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      n_checks++; if (m_if.m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", m_if.m_valid); end
      n_checks++; if (m_if.m_data !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 00", m_if.m_data); end
      repeat (3) @(negedge clk);
      rx_serial = 1'b1;
      rst = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rstmid_no_frame: got %0d frames expected 0", got_q.size()); end
      got_q.delete();
      send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
      repeat (BIT_CLKS) @(negedge clk);
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d frames expected %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) begin n_fail++; $display("FAIL rstmid_frame: got %h expected %h", g, e); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_random();
      test_back_to_back();
      test_frame_err();
      test_overrun();
      test_parity();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
